// File: rtl/seg7_display_monitor_pkg.sv
// Shared definitions for the seven-segment monitor: segment codes, tracking
// states and the modulo-10 successor used by the sequence check.
package seg7_mon_pkg;

  // Segment codes, bit0 = a ... bit6 = g, 1 = lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2
  } state_t;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_display_monitor_if.sv
// Signal bundle between the segment bus source (master) and the monitor (slave).
interface seg7_display_monitor_if #(
  parameter int CNT_W = 24
);
  import seg7_mon_pkg::*;

  // No handshake: ena qualifies segments each cycle; every *_stb / *_err
  // output is a single-cycle pulse that the consumer must sample when high.
  logic             ena;
  logic [6:0]       segments;
  logic [3:0]       digit;
  logic             digit_stb;
  logic [CNT_W-1:0] interval;
  logic             locked;
  logic             seq_err;
  logic             timing_err;
  logic             invalid_stb;
  logic [7:0]       err_cnt;
  state_t           state;

  modport master (
    output ena, segments,
    input  digit, digit_stb, interval, locked, seq_err, timing_err,
           invalid_stb, err_cnt, state
  );

  modport slave (
    input  ena, segments,
    output digit, digit_stb, interval, locked, seq_err, timing_err,
           invalid_stb, err_cnt, state
  );

endinterface

// File: rtl/seg7_display_monitor_decode.sv
// Combinational seven-segment to BCD decoder; any non-digit code is invalid.
module seg7_decode
  import seg7_mon_pkg::*;
(
  input  logic [6:0] segments,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (segments)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_display_monitor.sv
// Receive-side checker for a seven-segment seconds counter: glitch filter,
// decode, interval timestamping and sequence/timing/validity error flags.
module seg7_display_monitor
  import seg7_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 24,
  parameter int EXP_INTERVAL  = 1000,
  parameter int TOL           = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_display_monitor_if.slave bus
);

  localparam int               STAB_W   = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] INT_LO   = CNT_W'(EXP_INTERVAL - TOL);
  localparam logic [CNT_W-1:0] INT_HI   = CNT_W'(EXP_INTERVAL + TOL);

  logic [6:0]        cand;
  logic [6:0]        acc_pat;
  logic [STAB_W-1:0] stab_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  interval_q;
  logic [3:0]        digit_q;
  logic [7:0]        err_q;
  logic              stb_q, seq_q, tim_q, inv_q;
  state_t            state, next_state;

  logic              dec_valid;
  logic [3:0]        dec_digit;
  logic              accept;
  logic [CNT_W-1:0]  int_val;
  logic              in_tol;
  logic              stb_n, seq_n, tim_n, inv_n;

  seg7_decode u_decode (
    .segments (cand),
    .valid    (dec_valid),
    .digit    (dec_digit)
  );

  // The filter runs on the registered candidate, so an input change on the
  // accept cycle only restarts filtering; it cannot cancel this acceptance.
  assign accept  = bus.ena && (stab_cnt == STAB_MAX) && (cand != acc_pat);
  assign int_val = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign in_tol  = (int_val >= INT_LO) && (int_val <= INT_HI);

  always_comb begin
    next_state = state;
    stb_n      = 1'b0;
    seq_n      = 1'b0;
    tim_n      = 1'b0;
    inv_n      = 1'b0;
    if (accept) begin
      if (!dec_valid) begin
        inv_n      = 1'b1;
        next_state = IDLE;
      end else begin
        stb_n = 1'b1;
        case (state)
          IDLE:  next_state = FIRST;
          FIRST, TRACK: begin
            next_state = TRACK;
            seq_n      = (dec_digit != next_digit(digit_q));
            tim_n      = !in_tol;
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= SEG_BLANK;
      acc_pat    <= SEG_BLANK;
      stab_cnt   <= '0;
      cnt        <= '0;
      interval_q <= '0;
      digit_q    <= 4'd0;
      err_q      <= 8'd0;
      stb_q      <= 1'b0;
      seq_q      <= 1'b0;
      tim_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else if (bus.ena) begin
      state    <= next_state;
      cand     <= bus.segments;
      stab_cnt <= (bus.segments != cand) ? '0 :
                  (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
      stb_q    <= stb_n;
      seq_q    <= seq_n;
      tim_q    <= tim_n;
      inv_q    <= inv_n;
      if (accept) begin
        interval_q <= int_val;
        cnt        <= '0;
        acc_pat    <= cand;
        if (dec_valid) digit_q <= dec_digit;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      // One count per strobe cycle, however many flags coincide.
      if ((seq_n || tim_n || inv_n) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end else begin
      stb_q <= 1'b0;
      seq_q <= 1'b0;
      tim_q <= 1'b0;
      inv_q <= 1'b0;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_stb   = stb_q;
  assign bus.interval    = interval_q;
  assign bus.locked      = (state == TRACK);
  assign bus.seq_err     = seq_q;
  assign bus.timing_err  = tim_q;
  assign bus.invalid_stb = inv_q;
  assign bus.err_cnt     = err_q;
  assign bus.state       = state;

endmodule
